mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 1000, data-memory word depth used for the address range check.
REQ-002 SHALL have ports clk input 1, rising-edge clock; rst input 1, reset; one clock; reset is synchronous and active-high.
REQ-003 SHALL have requester ports, n=0 (core load/store) and n=1 (debug/DMA): req<n> in 1; we<n> in 1; addr<n> in 32, word address; wdata<n> in 32; dqm<n> in 2, size 00 byte / 01 half / 10 word.
REQ-004 SHALL have per-requester outputs gnt<n> out 1, request accepted; rvalid<n> out 1, completion pulse; rdata<n> out 32, read data; err<n> out 1, out-of-range flag valid with rvalid<n>.
REQ-005 SHALL have memory-side ports mem_addr out 32; mem_we out 1; mem_wdata out 32; mem_dqm out 2; mem_rdata in 32, combinational read of mem_addr.

Function
REQ-006 SHALL implement FSM states IDLE and ACCESS; IDLE->ACCESS on any gnt; ACCESS->IDLE unconditionally after 1 cycle.
REQ-007 SHALL assert gnt combinationally in IDLE only, to at most one requester; gnt is never asserted in ACCESS.
REQ-008 SHALL grant the only active requester when one req is high; on simultaneous req, SHALL grant the port not granted last (round-robin); the last-grant register resets to 1, so port 0 wins the first tie.
REQ-009 SHALL latch we, addr, wdata, dqm and the owner index on the gnt cycle; requesters hold req and fields stable until gnt; req may drop the cycle after gnt.
REQ-010 SHALL in ACCESS drive mem_addr/mem_wdata/mem_dqm from the latch and mem_we = latched we, for exactly one cycle.
REQ-011 SHALL in IDLE drive mem_we=0, mem_addr=0, mem_wdata=0, mem_dqm=2'b10.
REQ-012 SHALL register mem_rdata into the owner's rdata at the end of ACCESS; rvalid<owner> is a 1-cycle pulse in the following cycle; latency gnt->rvalid = 2 cycles.
REQ-013 SHALL give writes the same rvalid pulse; rdata then holds the pre-write memory word.
REQ-014 SHALL hold rdata<n> until that port's next completion; the non-owner's rvalid/rdata are untouched.
REQ-015 SHALL allow a new gnt in the same cycle as the previous rvalid (throughput 1 access / 2 cycles); a port requesting continuously against a continuous competitor alternates grants.
REQ-016 SHALL pass dqm unchanged; reserved dqm 2'b11 is forwarded and produces no memory update.

Reset
REQ-017 SHALL on rst: state=IDLE, gnt/rvalid/err/mem_we=0, rdata=0, latch cleared, last-grant=1.
REQ-018 SHALL on rst during ACCESS abort the access: mem_we=0 from the next edge and no rvalid issued for the aborted transaction.

Configuration
REQ-019 SHALL with MEM_ARB_RANGE_CHECK_EN defined flag latched addr >= MEM_DEPTH: mem_we forced 0 in ACCESS, rdata=0, err<owner>=1 with rvalid.
REQ-020 SHALL without MEM_ARB_RANGE_CHECK_EN forward all addresses unchanged and tie err0/err1 to 0; the ports still exist.

Structure
REQ-021 SHALL place the state encoding, DQM constants BYTE/HALF/WORD and the port-index type in shared package mem_arb_pkg.
REQ-022 SHALL implement the two-way round-robin choice in a sub-module rr_arbiter2 (req[1:0], last-grant -> one-hot grant).

Verification
REQ-023 SHALL cover: req0 alone, write addr=5 wdata=0xDEADBEEF dqm=10 -> gnt0 at cycle N, mem_we=1 at N+1, rvalid0 at N+2; a later read addr=5 returns 0xDEADBEEF.
REQ-024 SHALL cover: req0 and req1 both high from reset -> grants 0,1,0,1 on successive IDLE cycles; rvalid pulses 2 cycles after each gnt.
REQ-025 SHALL cover: req1 byte write wdata=0x000000AA dqm=00 to addr=7 holding 0x11223344 -> mem_dqm=00 in ACCESS; rdata1=0x11223344; a re-read gives 0x112233AA.
REQ-026 SHALL cover: rst asserted during ACCESS of a write -> no rvalid, mem_we=0 after the edge, state IDLE, next tie granted to port 0.
REQ-027 SHALL cover, with MEM_ARB_RANGE_CHECK_EN: write addr=1000 -> mem_we=0 in ACCESS, rvalid0=1, err0=1, rdata0=0; without the macro: mem_we=1 and err0=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  // Arbiter FSM: grants are only issued in StIdle; StAccess lasts exactly one cycle.
  typedef enum logic {
    StIdle   = 1'b0,
    StAccess = 1'b1
  } arb_state_e;

  // Access size encodings carried on dqm; 2'b11 is reserved and never updates memory.
  localparam logic [1:0] DQM_BYTE = 2'b00;
  localparam logic [1:0] DQM_HALF = 2'b01;
  localparam logic [1:0] DQM_WORD = 2'b10;
  localparam logic [1:0] DQM_RSVD = 2'b11;

  // Requester index: 0 = core load/store, 1 = debug/DMA.
  typedef logic port_idx_t;

  // Request fields captured on the grant cycle.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  dqm;
    port_idx_t   owner;
  } acc_latch_t;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin choice: a lone requester always wins, a tie goes to the port
// that was not granted last.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  port_idx_t  last_i,
  output logic [1:0] gnt_o
);

  // One-hot grant from the request pair and the last winner.
  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter. One access every two cycles: grant in
// IDLE, drive the memory for one ACCESS cycle, return data/rvalid the cycle after.
// Optional build macro MEM_ARB_RANGE_CHECK_EN: latched addresses >= MEM_DEPTH
// suppress the write, return rdata=0 and raise err with rvalid.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 1000
) (
  input  logic        clk,
  input  logic        rst,
  // Requester 0 (core load/store)
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic [1:0]  dqm0,
  output logic        gnt0,
  output logic        rvalid0,
  output logic [31:0] rdata0,
  output logic        err0,
  // Requester 1 (debug/DMA)
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  input  logic [1:0]  dqm1,
  output logic        gnt1,
  output logic        rvalid1,
  output logic [31:0] rdata1,
  output logic        err1,
  // Memory side
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_dqm,
  input  logic [31:0] mem_rdata
);

  arb_state_e       state_q, state_d;
  acc_latch_t       lat_q, lat_d;
  port_idx_t        last_q, last_d;
  logic [1:0]       rvalid_q, rvalid_d;
  logic [1:0]       err_q, err_d;
  logic [1:0][31:0] rdata_q, rdata_d;
  logic [1:0]       arb_gnt;
  logic [1:0]       gnt;
  logic             oor;

  rr_arbiter2 u_rr (
    .req_i  ({req1, req0}),
    .last_i (last_q),
    .gnt_o  (arb_gnt)
  );

`ifdef MEM_ARB_RANGE_CHECK_EN
  assign oor = (lat_q.addr >= 32'(MEM_DEPTH));
`else
  assign oor = 1'b0;
`endif

  // Next-state, grant and memory-side drive; IDLE defaults keep the bus quiet.
  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    last_d    = last_q;
    rvalid_d  = 2'b00;
    err_d     = 2'b00;
    rdata_d   = rdata_q;
    gnt       = 2'b00;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_dqm   = DQM_WORD;
    unique case (state_q)
      StIdle: begin
        // No grant while reset is held, so nothing is accepted that reset would drop.
        gnt = arb_gnt & {2{~rst}};
        if (gnt != 2'b00) begin
          state_d = StAccess;
          last_d  = gnt[1];
          if (gnt[1]) begin
            lat_d = '{we: we1, addr: addr1, wdata: wdata1, dqm: dqm1, owner: 1'b1};
          end else begin
            lat_d = '{we: we0, addr: addr0, wdata: wdata0, dqm: dqm0, owner: 1'b0};
          end
        end
      end
      StAccess: begin
        mem_addr  = lat_q.addr;
        mem_wdata = lat_q.wdata;
        mem_dqm   = lat_q.dqm;
        mem_we    = lat_q.we & ~oor;
        state_d   = StIdle;
        rvalid_d[lat_q.owner] = 1'b1;
        err_d[lat_q.owner]    = oor;
        rdata_d[lat_q.owner]  = oor ? 32'h0 : mem_rdata;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, latch and completion registers; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      lat_q    <= '0;
      last_q   <= 1'b1;
      rvalid_q <= 2'b00;
      err_q    <= 2'b00;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      last_q   <= last_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign gnt0    = gnt[0];
  assign gnt1    = gnt[1];
  assign rvalid0 = rvalid_q[0];
  assign rvalid1 = rvalid_q[1];
  assign err0    = err_q[0];
  assign err1    = err_q[1];
  assign rdata0  = rdata_q[0];
  assign rdata1  = rdata_q[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model (memory image, grant order, latency).
module tb_mem_arbiter;

  localparam int unsigned Depth = 1000;

`ifdef MEM_ARB_RANGE_CHECK_EN
  localparam bit RangeEn = 1'b1;
`else
  localparam bit RangeEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic [1:0]  dqm0, dqm1;
  logic        gnt0, rvalid0, err0, gnt1, rvalid1, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [1:0]  mem_dqm;

  int errors = 0;
  int checks = 0;

  // Memory stub seen by the DUT, and the bench's own expected memory image.
  logic [31:0] mem     [0:2047] = '{default: 32'h0};
  logic [31:0] ref_mem [0:2047] = '{default: 32'h0};
  logic        model_last;
  logic [31:0] hold_rd [2];

  typedef struct {
    logic [1:0]  gnt;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [1:0]  mdqm;
    logic [1:0]  rv_early;
    logic [1:0]  rv;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic [1:0]  err;
  } obs_t;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_DEPTH(Depth)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .dqm0(dqm0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .dqm1(dqm1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .err1(err1),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_dqm(mem_dqm), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[10:0]];

  always @(posedge clk) begin
    if (mem_we) begin
      case (mem_dqm)
        2'b00:   mem[mem_addr[10:0]][7:0]  <= mem_wdata[7:0];
        2'b01:   mem[mem_addr[10:0]][15:0] <= mem_wdata[15:0];
        2'b10:   mem[mem_addr[10:0]]       <= mem_wdata;
        default: ;
      endcase
    end
  end

  // Reference access: returns what the requester should read back, updates the image.
  function automatic logic [31:0] ref_access(input logic [31:0] addr, input logic we,
                                             input logic [31:0] wdata, input logic [1:0] dqm);
    logic [31:0] old;
    logic        oor;
    oor = RangeEn && (addr >= Depth);
    old = ref_mem[addr[10:0]];
    if (we && !oor) begin
      case (dqm)
        2'b00:   ref_mem[addr[10:0]] = {old[31:8], wdata[7:0]};
        2'b01:   ref_mem[addr[10:0]] = {old[31:16], wdata[15:0]};
        2'b10:   ref_mem[addr[10:0]] = wdata;
        default: ;
      endcase
    end
    return oor ? 32'h0 : old;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Single-requester transaction from an idle arbiter; records each phase.
  task automatic issue(input bit port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] dqm, output obs_t o);
    next_cycle();
    if (port) begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; dqm1 = dqm;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; dqm0 = dqm;
    end
    @(negedge clk);
    o.gnt = {gnt1, gnt0};
    next_cycle();
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    o.mwe = mem_we; o.maddr = mem_addr; o.mwdata = mem_wdata; o.mdqm = mem_dqm;
    o.rv_early = {rvalid1, rvalid0};
    next_cycle();
    @(negedge clk);
    o.rv = {rvalid1, rvalid0}; o.rd0 = rdata0; o.rd1 = rdata1; o.err = {err1, err0};
    model_last = port;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL rst_gnt_masked: got %b want 0", gnt0); end
    next_cycle();
    rst = 1'b0;
    req0 = 1'b0;
    @(negedge clk);
    checks++; if ({gnt1, gnt0} !== 2'b00) begin errors++; $display("FAIL rst_gnt: got %b want 00", {gnt1, gnt0}); end
    checks++; if ({rvalid1, rvalid0, err1, err0} !== 4'b0) begin errors++; $display("FAIL rst_rv_err: got %b want 0000", {rvalid1, rvalid0, err1, err0}); end
    checks++; if ({rdata1, rdata0} !== 64'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", {rdata1, rdata0}); end
    checks++; if ({mem_we, mem_addr, mem_wdata, mem_dqm} !== {1'b0, 64'h0, 2'b10}) begin
      errors++; $display("FAIL rst_idle_bus: got we=%b a=%h d=%h dqm=%b want 0/0/0/10", mem_we, mem_addr, mem_wdata, mem_dqm);
    end
    model_last = 1'b1;
    hold_rd[0] = 32'h0;
    hold_rd[1] = 32'h0;
  endtask

  task automatic test_write_read();
    obs_t o;
    logic [31:0] exp;
    issue(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, 2'b10, o);
    exp = ref_access(32'd5, 1'b1, 32'hDEADBEEF, 2'b10);
    hold_rd[0] = exp;
    checks++; if (o.gnt !== 2'b01) begin errors++; $display("FAIL wr_gnt: got %b want 01", o.gnt); end
    checks++; if ({o.mwe, o.maddr, o.mwdata, o.mdqm} !== {1'b1, 32'd5, 32'hDEADBEEF, 2'b10}) begin
      errors++; $display("FAIL wr_access: got we=%b a=%h d=%h dqm=%b want 1/5/deadbeef/10", o.mwe, o.maddr, o.mwdata, o.mdqm);
    end
    checks++; if (o.rv_early !== 2'b00) begin errors++; $display("FAIL wr_rv_early: got %b want 00", o.rv_early); end
    checks++; if (o.rv !== 2'b01) begin errors++; $display("FAIL wr_rvalid: got %b want 01", o.rv); end
    checks++; if (o.rd0 !== exp) begin errors++; $display("FAIL wr_rdata: got %h want %h", o.rd0, exp); end
    issue(1'b0, 1'b0, 32'd5, 32'h0, 2'b10, o);
    exp = ref_access(32'd5, 1'b0, 32'h0, 2'b10);
    hold_rd[0] = exp;
    checks++; if (o.mwe !== 1'b0) begin errors++; $display("FAIL rd_we: got %b want 0", o.mwe); end
    checks++; if (o.rv !== 2'b01) begin errors++; $display("FAIL rd_rvalid: got %b want 01", o.rv); end
    checks++; if (o.rd0 !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", o.rd0); end
    next_cycle();
    @(negedge clk);
    checks++; if ({rvalid0, rdata0} !== {1'b0, 32'hDEADBEEF}) begin
      errors++; $display("FAIL rd_hold: got rv=%b d=%h want 0/deadbeef", rvalid0, rdata0);
    end
  endtask

  task automatic test_round_robin();
    logic eg0, eg1, erv0, erv1;
    next_cycle();
    rst = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd5; dqm0 = 2'b10;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd2; dqm1 = 2'b10;
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) next_cycle();
      if (c == 7) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      @(negedge clk);
      eg0  = (c <= 6) && (c % 4 == 0);
      eg1  = (c <= 6) && (c % 4 == 2);
      erv0 = (c == 2) || (c == 6);
      erv1 = (c == 4) || (c == 8);
      checks++; if ({gnt1, gnt0} !== {eg1, eg0}) begin errors++; $display("FAIL rr_gnt c=%0d: got %b want %b", c, {gnt1, gnt0}, {eg1, eg0}); end
      checks++; if ({rvalid1, rvalid0} !== {erv1, erv0}) begin errors++; $display("FAIL rr_rvalid c=%0d: got %b want %b", c, {rvalid1, rvalid0}, {erv1, erv0}); end
      if (erv0) begin
        checks++; if (rdata0 !== ref_mem[5]) begin errors++; $display("FAIL rr_rdata0 c=%0d: got %h want %h", c, rdata0, ref_mem[5]); end
      end
      if (erv1) begin
        checks++; if (rdata1 !== ref_mem[2]) begin errors++; $display("FAIL rr_rdata1 c=%0d: got %h want %h", c, rdata1, ref_mem[2]); end
      end
    end
    model_last = 1'b1;
    hold_rd[0] = ref_mem[5];
    hold_rd[1] = ref_mem[2];
  endtask

  task automatic test_byte_write();
    obs_t o;
    logic [31:0] exp;
    issue(1'b1, 1'b1, 32'd7, 32'h11223344, 2'b10, o);
    hold_rd[1] = ref_access(32'd7, 1'b1, 32'h11223344, 2'b10);
    checks++; if (o.gnt !== 2'b10) begin errors++; $display("FAIL bw_setup_gnt: got %b want 10", o.gnt); end
    issue(1'b1, 1'b1, 32'd7, 32'h000000AA, 2'b00, o);
    exp = ref_access(32'd7, 1'b1, 32'h000000AA, 2'b00);
    hold_rd[1] = exp;
    checks++; if ({o.mwe, o.mdqm} !== {1'b1, 2'b00}) begin errors++; $display("FAIL bw_dqm: got we=%b dqm=%b want 1/00", o.mwe, o.mdqm); end
    checks++; if (o.rv !== 2'b10) begin errors++; $display("FAIL bw_rvalid: got %b want 10", o.rv); end
    checks++; if (o.rd1 !== 32'h11223344) begin errors++; $display("FAIL bw_prewrite: got %h want 11223344", o.rd1); end
    checks++; if (o.rd0 !== hold_rd[0]) begin errors++; $display("FAIL bw_other_port: got %h want %h", o.rd0, hold_rd[0]); end
    issue(1'b1, 1'b1, 32'd7, 32'hFFFFFFFF, 2'b11, o);
    hold_rd[1] = ref_access(32'd7, 1'b1, 32'hFFFFFFFF, 2'b11);
    checks++; if (o.mdqm !== 2'b11) begin errors++; $display("FAIL bw_rsvd_fwd: got %b want 11", o.mdqm); end
    issue(1'b1, 1'b0, 32'd7, 32'h0, 2'b10, o);
    hold_rd[1] = ref_access(32'd7, 1'b0, 32'h0, 2'b10);
    checks++; if (o.rd1 !== 32'h112233AA) begin errors++; $display("FAIL bw_reread: got %h want 112233aa", o.rd1); end
  endtask

  task automatic test_reset_during_access();
    next_cycle();
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd9; wdata0 = 32'hCAFEF00D; dqm0 = 2'b10;
    @(negedge clk);
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL ra_gnt: got %b want 1", gnt0); end
    void'(ref_access(32'd9, 1'b1, 32'hCAFEF00D, 2'b10));
    next_cycle();
    req0 = 1'b0;
    @(negedge clk);
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL ra_access_we: got %b want 1", mem_we); end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({rvalid1, rvalid0} !== 2'b00) begin errors++; $display("FAIL ra_no_rvalid: got %b want 00", {rvalid1, rvalid0}); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL ra_we_after: got %b want 0", mem_we); end
    checks++; if ({rdata1, rdata0} !== 64'h0) begin errors++; $display("FAIL ra_rdata_clr: got %h want 0", {rdata1, rdata0}); end
    next_cycle();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd5;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd7;
    @(negedge clk);
    checks++; if ({gnt1, gnt0} !== 2'b01) begin errors++; $display("FAIL ra_tie_gnt: got %b want 01", {gnt1, gnt0}); end
    next_cycle();
    req0 = 1'b0;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    checks++; if ({gnt1, rvalid0, rdata0} !== {1'b1, 1'b1, ref_mem[5]}) begin
      errors++; $display("FAIL ra_second: got gnt1=%b rv0=%b d=%h want 1/1/%h", gnt1, rvalid0, rdata0, ref_mem[5]);
    end
    next_cycle();
    req1 = 1'b0;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    checks++; if ({rvalid1, rdata1} !== {1'b1, ref_mem[7]}) begin
      errors++; $display("FAIL ra_port1_done: got rv1=%b d=%h want 1/%h", rvalid1, rdata1, ref_mem[7]);
    end
    model_last = 1'b1;
    hold_rd[0] = ref_mem[5];
    hold_rd[1] = ref_mem[7];
  endtask

  task automatic test_range();
    obs_t o;
    logic [31:0] exp;
    issue(1'b0, 1'b1, 32'd1000, 32'h12345678, 2'b10, o);
    exp = ref_access(32'd1000, 1'b1, 32'h12345678, 2'b10);
    hold_rd[0] = exp;
    checks++; if ({o.mwe, o.maddr} !== {!RangeEn, 32'd1000}) begin
      errors++; $display("FAIL rng_we: got we=%b a=%h want %b/3e8", o.mwe, o.maddr, !RangeEn);
    end
    checks++; if ({o.rv, o.err} !== {2'b01, 1'b0, RangeEn}) begin
      errors++; $display("FAIL rng_err: got rv=%b err=%b want 01/0%b", o.rv, o.err, RangeEn);
    end
    checks++; if (o.rd0 !== exp) begin errors++; $display("FAIL rng_rdata: got %h want %h", o.rd0, exp); end
  endtask

  task automatic test_random();
    logic [1:0]  pend, granted, done, exp_g, exp_rv;
    logic        pwe [2];
    logic [31:0] paddr [2];
    logic [31:0] pwdata [2];
    logic [1:0]  pdqm [2];
    logic [31:0] exp_rd [2];
    int          gc [2];
    int          q;
    logic        busy;
    for (int it = 0; it < 80; it++) begin
      pend = 2'($urandom_range(1, 3));
      for (int p = 0; p < 2; p++) begin
        pwe[p]    = 1'($urandom_range(0, 1));
        paddr[p]  = 32'($urandom_range(0, 15));
        pwdata[p] = $urandom;
        pdqm[p]   = 2'($urandom_range(0, 3));
        gc[p]     = -10;
      end
      granted = 2'b00;
      done    = 2'b00;
      for (int c = 0; c < 12 && done != pend; c++) begin
        next_cycle();
        if (c == 0) begin
          req0 = pend[0]; we0 = pwe[0]; addr0 = paddr[0]; wdata0 = pwdata[0]; dqm0 = pdqm[0];
          req1 = pend[1]; we1 = pwe[1]; addr1 = paddr[1]; wdata1 = pwdata[1]; dqm1 = pdqm[1];
        end
        if (gc[0] == c - 1) req0 = 1'b0;
        if (gc[1] == c - 1) req1 = 1'b0;
        @(negedge clk);
        // An access occupies the cycle after its grant; a tie goes to the port not granted last.
        busy  = (gc[0] == c - 1) || (gc[1] == c - 1);
        exp_g = 2'b00;
        if (!busy) begin
          if ((pend & ~granted) == 2'b11) exp_g = model_last ? 2'b01 : 2'b10;
          else exp_g = pend & ~granted;
        end
        checks++; if ({gnt1, gnt0} !== exp_g) begin errors++; $display("FAIL rnd_gnt it=%0d c=%0d: got %b want %b", it, c, {gnt1, gnt0}, exp_g); end
        if (exp_g != 2'b00) begin
          q = exp_g[1] ? 1 : 0;
          gc[q] = c;
          granted[q] = 1'b1;
          model_last = exp_g[1];
          exp_rd[q] = ref_access(paddr[q], pwe[q], pwdata[q], pdqm[q]);
        end
        for (int p = 0; p < 2; p++) begin
          if (gc[p] == c - 1) begin
            checks++; if ({mem_we, mem_addr, mem_wdata, mem_dqm} !== {pwe[p], paddr[p], pwdata[p], pdqm[p]}) begin
              errors++; $display("FAIL rnd_access it=%0d p=%0d: got we=%b a=%h d=%h dqm=%b want %b/%h/%h/%b",
                                 it, p, mem_we, mem_addr, mem_wdata, mem_dqm, pwe[p], paddr[p], pwdata[p], pdqm[p]);
            end
          end
        end
        exp_rv = {gc[1] == c - 2, gc[0] == c - 2};
        checks++; if ({rvalid1, rvalid0} !== exp_rv) begin errors++; $display("FAIL rnd_rvalid it=%0d c=%0d: got %b want %b", it, c, {rvalid1, rvalid0}, exp_rv); end
        for (int p = 0; p < 2; p++) begin
          if (exp_rv[p]) begin
            hold_rd[p] = exp_rd[p];
            done[p] = 1'b1;
          end
        end
        checks++; if ({err1, err0} !== 2'b00) begin errors++; $display("FAIL rnd_err it=%0d: got %b want 00", it, {err1, err0}); end
        checks++; if ({rdata1, rdata0} !== {hold_rd[1], hold_rd[0]}) begin
          errors++; $display("FAIL rnd_rdata it=%0d c=%0d: got %h/%h want %h/%h", it, c, rdata1, rdata0, hold_rd[1], hold_rd[0]);
        end
      end
      checks++; if (done !== pend) begin errors++; $display("FAIL rnd_timeout it=%0d: got done=%b want %b", it, done, pend); end
      req0 = 1'b0;
      req1 = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0; dqm0 = 2'b10;
    req1 = 1'b0; we1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0; dqm1 = 2'b10;
    test_reset();
    test_write_read();
    test_round_robin();
    test_byte_write();
    test_reset_during_access();
    test_range();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want completion before time limit");
    $fatal(1);
  end

endmodule
